// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-unit bus: pipeline-stage register fields in, stall/flush/forward controls out.
// The master side is the datapath; the slave side is the hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
);
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic              ex_regwr;
  logic              ex_memrd;
  logic [REG_AW-1:0] ex_rdes;
  logic              mem_regwr;
  logic              mem_memrd;
  logic [REG_AW-1:0] mem_rdes;
  logic              mem_ready;
  logic              br_taken;
  logic              jump_id;
  logic              irq;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              stall;
  logic              mem_hold;
  logic              if_flush;
  logic              id_flush;
  logic              irq_ack;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, ex_regwr, ex_memrd, ex_rdes,
           mem_regwr, mem_memrd, mem_rdes, mem_ready, br_taken, jump_id, irq,
    input  fwd_a, fwd_b, stall, mem_hold, if_flush, id_flush, irq_ack, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, ex_regwr, ex_memrd, ex_rdes,
           mem_regwr, mem_memrd, mem_rdes, mem_ready, br_taken, jump_id, irq,
    output fwd_a, fwd_b, stall, mem_hold, if_flush, id_flush, irq_ack, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for a 5-stage MIPS: load-use stall, branch/jump/IRQ flush,
// multi-cycle memory wait, registered forward selects and saturating event counters.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned IRQ_FLUSH = 1
) (
  input logic               sysclk,
  input logic               Reset_n,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [1:0] StRun     = 2'd0;
  localparam logic [1:0] StMemWait = 2'd1;
  localparam logic [1:0] StIrqf    = 2'd2;
  localparam logic [2:0] IrqLen    = 3'(IRQ_FLUSH);

  logic [1:0]       state_q, state_d;
  logic             irq_pend_q, irq_pend_d;
  logic [2:0]       irq_cnt_q, irq_cnt_d;
  logic [1:0]       fwd_a_q, fwd_a_d;
  logic [1:0]       fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic load_use, mem_wait_start;
  logic stall, mem_hold, if_flush, id_flush, irq_ack;

  function automatic logic hit(input logic [REG_AW-1:0] s, input logic [REG_AW-1:0] x,
                               input logic use_x);
    return (x != '0) && use_x && (s == x);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit);
    if (ex_hit) return 2'b10;
    if (mem_hit) return 2'b01;
    return 2'b00;
  endfunction

  assign load_use = bus.ex_memrd && bus.ex_regwr &&
                    (hit(bus.ex_rdes, bus.id_rs, bus.id_use_rs) ||
                     hit(bus.ex_rdes, bus.id_rt, bus.id_use_rt));

  // The load that first misses is already frozen in its detect cycle, not one cycle later.
  assign mem_wait_start = bus.mem_memrd && !bus.mem_ready;

  always_comb begin
    state_d    = state_q;
    irq_cnt_d  = irq_cnt_q;
    irq_pend_d = irq_pend_q | bus.irq;
    stall      = 1'b0;
    mem_hold   = 1'b0;
    if_flush   = 1'b0;
    id_flush   = 1'b0;
    irq_ack    = 1'b0;
    if (Reset_n) begin
      case (state_q)
        StRun: begin
          if (mem_wait_start) begin
            stall    = 1'b1;
            mem_hold = 1'b1;
            state_d  = StMemWait;
          end else begin
            if (bus.br_taken) begin
              if_flush = 1'b1;
              id_flush = 1'b1;
            end else if (load_use) begin
              stall    = 1'b1;
              id_flush = 1'b1;
            end else if (bus.jump_id) begin
              if_flush = 1'b1;
            end
            if (irq_pend_q && !load_use) begin
              irq_ack    = 1'b1;
              irq_pend_d = 1'b0;
              irq_cnt_d  = IrqLen;
              state_d    = StIrqf;
            end
          end
        end
        StMemWait: begin
          stall    = 1'b1;
          mem_hold = 1'b1;
          if (bus.mem_ready) state_d = StRun;
        end
        StIrqf: begin
          if_flush = 1'b1;
          id_flush = 1'b1;
          if (irq_cnt_q <= 3'd1) state_d = StRun;
          else irq_cnt_d = irq_cnt_q - 3'd1;
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_comb begin
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    if (!mem_hold) begin
      if (stall || id_flush) begin
        fwd_a_d = 2'b00;
        fwd_b_d = 2'b00;
      end else begin
        fwd_a_d = fwd_sel(bus.ex_regwr && hit(bus.ex_rdes, bus.id_rs, bus.id_use_rs),
                          bus.mem_regwr && hit(bus.mem_rdes, bus.id_rs, bus.id_use_rs));
        fwd_b_d = fwd_sel(bus.ex_regwr && hit(bus.ex_rdes, bus.id_rt, bus.id_use_rt),
                          bus.mem_regwr && hit(bus.mem_rdes, bus.id_rt, bus.id_use_rt));
      end
    end
  end

  always_ff @(posedge sysclk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= StRun;
      irq_pend_q  <= 1'b0;
      irq_cnt_q   <= 3'd0;
      fwd_a_q     <= 2'b00;
      fwd_b_q     <= 2'b00;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      irq_pend_q <= irq_pend_d;
      irq_cnt_q  <= irq_cnt_d;
      fwd_a_q    <= fwd_a_d;
      fwd_b_q    <= fwd_b_d;
      if (stall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (id_flush && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign bus.fwd_a     = fwd_a_q;
  assign bus.fwd_b     = fwd_b_q;
  assign bus.stall     = stall;
  assign bus.mem_hold  = mem_hold;
  assign bus.if_flush  = if_flush;
  assign bus.id_flush  = id_flush;
  assign bus.irq_ack   = irq_ack;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic, every cycle compared
// against a cycle-level behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;
  localparam int unsigned AW   = 5;
  localparam int unsigned CW   = 4;
  localparam int unsigned IFN  = 2;
  localparam int          CMAX = (1 << CW) - 1;

  logic sysclk  = 1'b0;
  logic Reset_n = 1'b0;
  always #5 sysclk = ~sysclk;

  pipe_hazard_ctrl_if #(.REG_AW(AW), .CNT_W(CW)) bus ();

  pipe_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW), .IRQ_FLUSH(IFN)) dut (
    .sysclk (sysclk),
    .Reset_n(Reset_n),
    .bus    (bus)
  );

  int nvec  = 0;
  int nfail = 0;

  // Model state: waiting on memory, remaining IRQ flush cycles, pending IRQ, registered outputs.
  bit m_wait, m_pend;
  int m_flush_left, m_fa, m_fb, m_sc, m_fc;
  bit n_wait, n_pend;
  int n_flush_left, n_fa, n_fb, n_sc, n_fc;
  int e_stall, e_hold, e_if, e_id, e_ack;

  task automatic chk(input string tag, input logic [15:0] obs, input int exp);
    nvec++;
    assert (obs === 16'(exp)) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit mhit(input int s, input int x, input bit u);
    return (x != 0) && u && (s == x);
  endfunction

  function automatic int pick(input bit ex_m, input bit mem_m);
    return ex_m ? 2 : (mem_m ? 1 : 0);
  endfunction

  task automatic model_reset();
    m_wait = 0; m_pend = 0; m_flush_left = 0;
    m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0;
  endtask

  task automatic model_eval();
    bit lu;
    e_stall = 0; e_hold = 0; e_if = 0; e_id = 0; e_ack = 0;
    n_wait = m_wait; n_flush_left = m_flush_left; n_pend = m_pend || (bus.irq === 1'b1);
    lu = bus.ex_memrd && bus.ex_regwr &&
         (mhit(int'(bus.ex_rdes), int'(bus.id_rs), bus.id_use_rs) ||
          mhit(int'(bus.ex_rdes), int'(bus.id_rt), bus.id_use_rt));
    if (Reset_n) begin
      if (m_wait) begin
        e_stall = 1; e_hold = 1;
        if (bus.mem_ready) n_wait = 0;
      end else if (m_flush_left > 0) begin
        e_if = 1; e_id = 1;
        n_flush_left = m_flush_left - 1;
      end else if (bus.mem_memrd && !bus.mem_ready) begin
        e_stall = 1; e_hold = 1; n_wait = 1;
      end else begin
        if (bus.br_taken) begin e_if = 1; e_id = 1; end
        else if (lu) begin e_stall = 1; e_id = 1; end
        else if (bus.jump_id) e_if = 1;
        if (m_pend && !lu) begin
          e_ack = 1; n_pend = 0; n_flush_left = IFN;
        end
      end
    end
    n_fa = m_fa; n_fb = m_fb;
    if (!e_hold) begin
      if (e_stall || e_id) begin
        n_fa = 0; n_fb = 0;
      end else begin
        n_fa = pick(bus.ex_regwr && mhit(int'(bus.ex_rdes), int'(bus.id_rs), bus.id_use_rs),
                    bus.mem_regwr && mhit(int'(bus.mem_rdes), int'(bus.id_rs), bus.id_use_rs));
        n_fb = pick(bus.ex_regwr && mhit(int'(bus.ex_rdes), int'(bus.id_rt), bus.id_use_rt),
                    bus.mem_regwr && mhit(int'(bus.mem_rdes), int'(bus.id_rt), bus.id_use_rt));
      end
    end
    n_sc = (m_sc + e_stall > CMAX) ? CMAX : m_sc + e_stall;
    n_fc = (m_fc + e_id > CMAX) ? CMAX : m_fc + e_id;
  endtask

  task automatic model_commit();
    if (!Reset_n) model_reset();
    else begin
      m_wait = n_wait; m_pend = n_pend; m_flush_left = n_flush_left;
      m_fa = n_fa; m_fb = n_fb; m_sc = n_sc; m_fc = n_fc;
    end
  endtask

  task automatic tick();
    #1;
    model_eval();
    chk("fwd_a", 16'(bus.fwd_a), m_fa);
    chk("fwd_b", 16'(bus.fwd_b), m_fb);
    chk("stall", 16'(bus.stall), e_stall);
    chk("mem_hold", 16'(bus.mem_hold), e_hold);
    chk("if_flush", 16'(bus.if_flush), e_if);
    chk("id_flush", 16'(bus.id_flush), e_id);
    chk("irq_ack", 16'(bus.irq_ack), e_ack);
    chk("stall_cnt", 16'(bus.stall_cnt), m_sc);
    chk("flush_cnt", 16'(bus.flush_cnt), m_fc);
    @(posedge sysclk);
    model_commit();
    #1;
  endtask

  task automatic idle();
    bus.id_rs = '0; bus.id_rt = '0; bus.id_use_rs = 0; bus.id_use_rt = 0;
    bus.ex_regwr = 0; bus.ex_memrd = 0; bus.ex_rdes = '0;
    bus.mem_regwr = 0; bus.mem_memrd = 0; bus.mem_rdes = '0; bus.mem_ready = 0;
    bus.br_taken = 0; bus.jump_id = 0; bus.irq = 0;
  endtask

  task automatic do_reset();
    idle();
    Reset_n = 0;
    #1;
    model_reset();
    tick();
    Reset_n = 1;
  endtask

  initial begin
    idle();
    model_reset();
    // Reset state
    #2;
    chk("rst_stall", 16'(bus.stall), 0);
    chk("rst_fwd_a", 16'(bus.fwd_a), 0);
    tick();
    tick();
    Reset_n = 1;
    tick();

    // Load-use stall, then forward from MEM once the load has moved on
    bus.ex_memrd = 1; bus.ex_regwr = 1; bus.ex_rdes = 5'd8; bus.id_rs = 5'd8; bus.id_use_rs = 1;
    #1;
    chk("lu_stall", 16'(bus.stall), 1);
    chk("lu_id_flush", 16'(bus.id_flush), 1);
    chk("lu_if_flush", 16'(bus.if_flush), 0);
    tick();
    idle();
    bus.mem_regwr = 1; bus.mem_memrd = 1; bus.mem_ready = 1; bus.mem_rdes = 5'd8;
    bus.id_rs = 5'd8; bus.id_use_rs = 1;
    #1;
    chk("lu_next_stall", 16'(bus.stall), 0);
    tick();
    idle();
    #1;
    chk("lu_fwd_a_wb", 16'(bus.fwd_a), 1);
    tick();

    // EX beats MEM; register 0 never forwards
    bus.ex_regwr = 1; bus.ex_rdes = 5'd5; bus.mem_regwr = 1; bus.mem_rdes = 5'd5;
    bus.id_rt = 5'd5; bus.id_use_rt = 1;
    tick();
    bus.ex_rdes = 5'd0; bus.id_rt = 5'd0;
    #1;
    chk("fwd_b_ex_prio", 16'(bus.fwd_b), 2);
    tick();
    idle();
    #1;
    chk("fwd_b_r0", 16'(bus.fwd_b), 0);
    tick();

    // Memory wait: four held cycles, forward select frozen
    do_reset();
    bus.ex_regwr = 1; bus.ex_rdes = 5'd3; bus.id_rs = 5'd3; bus.id_use_rs = 1;
    tick();
    idle();
    bus.mem_memrd = 1; bus.mem_ready = 0; bus.mem_regwr = 1; bus.mem_rdes = 5'd3;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.mem_ready = 1;
      #1;
      chk("mw_stall", 16'(bus.stall), 1);
      chk("mw_hold", 16'(bus.mem_hold), 1);
      chk("mw_fwd_a_held", 16'(bus.fwd_a), 2);
      tick();
    end
    idle();
    #1;
    chk("mw_stall_after", 16'(bus.stall), 0);
    chk("mw_stall_cnt", 16'(bus.stall_cnt), 4);
    tick();

    // Branch overrides a coincident load-use
    bus.ex_memrd = 1; bus.ex_regwr = 1; bus.ex_rdes = 5'd8; bus.id_rs = 5'd8; bus.id_use_rs = 1;
    bus.br_taken = 1;
    #1;
    chk("br_if_flush", 16'(bus.if_flush), 1);
    chk("br_id_flush", 16'(bus.id_flush), 1);
    chk("br_stall", 16'(bus.stall), 0);
    tick();
    idle();
    #1;
    chk("br_flush_cnt", 16'(bus.flush_cnt), 1);
    tick();

    // IRQ raised in MEMWAIT is taken after exit, then two flush cycles
    bus.mem_memrd = 1; bus.mem_ready = 0;
    tick();
    bus.irq = 1;
    tick();
    bus.irq = 0; bus.mem_ready = 1;
    #1;
    chk("irq_ack_exit", 16'(bus.irq_ack), 0);
    tick();
    idle();
    #1;
    chk("irq_ack_take", 16'(bus.irq_ack), 1);
    tick();
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("irqf_if_flush", 16'(bus.if_flush), 1);
      chk("irqf_id_flush", 16'(bus.id_flush), 1);
      chk("irqf_ack", 16'(bus.irq_ack), 0);
      tick();
    end
    #1;
    chk("irqf_done", 16'(bus.if_flush), 0);
    tick();

    // Asynchronous reset in the middle of MEMWAIT with an IRQ latched
    bus.mem_memrd = 1; bus.mem_ready = 0; bus.irq = 1;
    tick();
    bus.irq = 0;
    Reset_n = 0;
    #1;
    chk("ar_stall", 16'(bus.stall), 0);
    chk("ar_hold", 16'(bus.mem_hold), 0);
    chk("ar_fwd_a", 16'(bus.fwd_a), 0);
    chk("ar_stall_cnt", 16'(bus.stall_cnt), 0);
    chk("ar_flush_cnt", 16'(bus.flush_cnt), 0);
    model_reset();
    tick();
    Reset_n = 1;
    idle();
    tick();
    tick();

    // Counter saturation
    bus.mem_memrd = 1; bus.mem_ready = 0;
    for (int i = 0; i < 20; i++) tick();
    bus.mem_ready = 1;
    tick();
    idle();
    #1;
    chk("stall_cnt_sat", 16'(bus.stall_cnt), CMAX);
    tick();
    bus.br_taken = 1;
    for (int i = 0; i < 20; i++) tick();
    idle();
    #1;
    chk("flush_cnt_sat", 16'(bus.flush_cnt), CMAX);
    tick();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if (i % 97 == 96) do_reset();
      bus.id_rs     = 5'($urandom_range(0, 3));
      bus.id_rt     = 5'($urandom_range(0, 3));
      bus.id_use_rs = 1'($urandom_range(0, 1));
      bus.id_use_rt = 1'($urandom_range(0, 1));
      bus.ex_regwr  = 1'($urandom_range(0, 1));
      bus.ex_memrd  = ($urandom_range(0, 2) == 0);
      bus.ex_rdes   = 5'($urandom_range(0, 3));
      bus.mem_regwr = 1'($urandom_range(0, 1));
      bus.mem_memrd = ($urandom_range(0, 4) == 0);
      bus.mem_rdes  = 5'($urandom_range(0, 3));
      bus.mem_ready = ($urandom_range(0, 2) != 0);
      bus.br_taken  = ($urandom_range(0, 7) == 0);
      bus.jump_id   = ($urandom_range(0, 7) == 0);
      bus.irq       = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
